// File: rtl/msp_spi_initiator.sv
// Half-duplex mode-3 SPI initiator: shifts out a 64-bit command, turns the line around, clocks in N bytes.
// done lands 2*CLK_DIV*(64+T+8N)+1 cycles after acceptance; cmd_ready is low for the whole transfer.
module msp_spi_initiator #(
   parameter int CLK_DIV   = 2,
   parameter int TURN_BITS = 8
) (
   input  logic        clk,
   input  logic        rst_,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [63:0] cmd_data,
   input  logic [7:0]  resp_len,
   output logic [7:0]  resp_data,
   output logic        resp_valid,
   output logic        busy,
   output logic        done,
   output logic        spi_clk,
   output logic        spi_data_o,
   output logic        spi_data_oe,
   input  logic        spi_data_i
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CMD  = 2'd1;
   localparam logic [1:0] S_TURN = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
   localparam logic [8:0] CMD_LAST   = 9'd63;
   localparam logic [8:0] TURN_LAST  = 9'(TURN_BITS - 1);

   logic [1:0]  state;
   logic [63:0] shreg;
   logic [7:0]  byte_cnt;
   logic [8:0]  bit_cnt;
   logic [7:0]  div_cnt;
   logic [7:0]  rx;
   logic        fin;
   logic        byte_pend;

   assign cmd_ready = (state == S_IDLE);

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state       <= S_IDLE;
         shreg       <= '0;
         byte_cnt    <= '0;
         bit_cnt     <= '0;
         div_cnt     <= '0;
         rx          <= '0;
         fin         <= 1'b0;
         byte_pend   <= 1'b0;
         resp_data   <= '0;
         resp_valid  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         spi_clk     <= 1'b1;
         spi_data_o  <= 1'b0;
         spi_data_oe <= 1'b0;
      end else begin
         done       <= 1'b0;
         byte_pend  <= 1'b0;
         resp_valid <= byte_pend;
         if (byte_pend)
            resp_data <= rx;

         if (state == S_IDLE) begin
            if (cmd_valid) begin
               state    <= S_CMD;
               shreg    <= cmd_data;
               byte_cnt <= resp_len;
               bit_cnt  <= '0;
               div_cnt  <= '0;   // first falling edge on the very next cycle
               fin      <= 1'b0;
            end
         end else if (div_cnt != 8'd0) begin
            div_cnt <= div_cnt - 8'd1;
         end else begin
            div_cnt <= DIV_RELOAD;
            if (spi_clk) begin
               // the falling edge that would start another bit instead ends the transfer
               if (fin) begin
                  state       <= S_IDLE;
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  spi_data_oe <= 1'b0;
                  spi_data_o  <= 1'b0;
               end else begin
                  spi_clk <= 1'b0;
                  busy    <= 1'b1;
                  if (state == S_CMD) begin
                     spi_data_oe <= 1'b1;
                     spi_data_o  <= shreg[63];
                     shreg       <= {shreg[62:0], 1'b0};
                  end else begin
                     spi_data_oe <= 1'b0;
                     spi_data_o  <= 1'b0;
                  end
               end
            end else begin
               spi_clk <= 1'b1;
               case (state)
                  S_CMD: begin
                     if (bit_cnt == CMD_LAST) begin
                        bit_cnt <= '0;
                        if (byte_cnt == 8'd0)
                           fin <= 1'b1;
                        else
                           state <= S_TURN;
                     end else begin
                        bit_cnt <= bit_cnt + 9'd1;
                     end
                  end
                  S_TURN: begin
                     if (bit_cnt == TURN_LAST) begin
                        bit_cnt <= '0;
                        state   <= S_RESP;
                     end else begin
                        bit_cnt <= bit_cnt + 9'd1;
                     end
                  end
                  S_RESP: begin
                     rx <= {rx[6:0], spi_data_i};
                     if (bit_cnt[2:0] == 3'd7) begin
                        bit_cnt   <= '0;
                        byte_pend <= 1'b1;
                        if (byte_cnt == 8'd1)
                           fin <= 1'b1;
                        else
                           byte_cnt <= byte_cnt - 8'd1;
                     end else begin
                        bit_cnt <= bit_cnt + 9'd1;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_msp_spi_initiator.sv
// Bench for msp_spi_initiator: two instances (CLK_DIV 2 and 1) against a cycle-offset model of the wire timeline.
module tb_msp_spi_initiator;
   localparam int T = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_;
   logic [1:0]  cmd_valid;
   logic [63:0] cmd_data;
   logic [7:0]  resp_len;
   logic [1:0]  sdi = 2'b00;
   wire  [1:0]  cmd_ready_w, resp_valid_w, busy_w, done_w, sclk_w, sdo_w, soe_w;
   wire  [7:0]  rd0, rd1;

   msp_spi_initiator #(.CLK_DIV(2), .TURN_BITS(T)) u_d2 (
      .clk(clk), .rst_(rst_), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready_w[0]),
      .cmd_data(cmd_data), .resp_len(resp_len), .resp_data(rd0), .resp_valid(resp_valid_w[0]),
      .busy(busy_w[0]), .done(done_w[0]), .spi_clk(sclk_w[0]), .spi_data_o(sdo_w[0]),
      .spi_data_oe(soe_w[0]), .spi_data_i(sdi[0]));

   msp_spi_initiator #(.CLK_DIV(1), .TURN_BITS(T)) u_d1 (
      .clk(clk), .rst_(rst_), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready_w[1]),
      .cmd_data(cmd_data), .resp_len(resp_len), .resp_data(rd1), .resp_valid(resp_valid_w[1]),
      .busy(busy_w[1]), .done(done_w[1]), .spi_clk(sclk_w[1]), .spi_data_o(sdo_w[1]),
      .spi_data_oe(soe_w[1]), .spi_data_i(sdi[1]));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s inst%0d got=%0h exp=%0h t=%0t", nm, i, act, exp, $time);
      end
   endtask

   function automatic int dv(input int i);
      return (i == 0) ? 2 : 1;
   endfunction

   function automatic int done_at(input int i, input int n);
      return 2 * dv(i) * (64 + ((n > 0) ? T : 0) + 8 * n) + 1;
   endfunction

   // Model: each transaction is a timeline indexed by cycles since acceptance.
   bit          m_act [2] = '{0, 0};
   int          m_c   [2] = '{0, 0};
   int          m_n   [2] = '{0, 0};
   int          m_done[2] = '{0, 0};
   int          acc_id[2] = '{0, 0};
   logic [63:0] m_cmd [2];
   logic [7:0]  m_rb  [2][256];
   logic [7:0]  nxt_rb[2][256];
   logic [7:0]  m_rd  [2] = '{8'h00, 8'h00};
   logic e_clk[2], e_busy[2], e_done[2], e_oe[2], e_do[2], e_rdy[2], e_rv[2];

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int c, d, b, r, bb;
         bit rdy;
         d = dv(i);
         if (!rst_) begin
            m_act[i] = 0;
            m_rd[i]  = 8'h00;
         end else begin
            rdy = !m_act[i] || (m_c[i] == m_done[i]);
            if (cmd_valid[i] && rdy) begin
               m_act[i]  = 1;
               m_c[i]    = 0;
               m_cmd[i]  = cmd_data;
               m_n[i]    = int'(resp_len);
               m_done[i] = done_at(i, m_n[i]);
               for (int k = 0; k < 256; k++) m_rb[i][k] = nxt_rb[i][k];
               acc_id[i]++;
            end else if (m_act[i]) begin
               m_c[i]++;
               if (m_c[i] > m_done[i]) m_act[i] = 0;
            end
         end
         e_clk[i] = 1; e_busy[i] = 0; e_done[i] = 0; e_oe[i] = 0;
         e_do[i] = 0; e_rdy[i] = 1; e_rv[i] = 0;
         if (m_act[i]) begin
            c = m_c[i];
            if (c == 0) begin
               e_rdy[i] = 0;
            end else if (c < m_done[i]) begin
               e_rdy[i]  = 0;
               e_busy[i] = 1;
               b = (c - 1) / (2 * d);
               e_clk[i] = (((c - 1) % (2 * d)) >= d);
               if (b < 64) begin
                  e_oe[i] = 1;
                  e_do[i] = m_cmd[i][63 - b];
               end
            end else begin
               e_done[i] = 1;
            end
            // strobe lands one cycle after the rising edge of each byte's last bit
            if (m_n[i] > 0 && c >= d + 2) begin
               r = c - 2 - d;
               if (r % (2 * d) == 0) begin
                  bb = r / (2 * d) - 64 - T;
                  if (bb >= 0 && bb % 8 == 7 && bb / 8 < m_n[i]) begin
                     e_rv[i] = 1;
                     m_rd[i] = m_rb[i][bb / 8];
                  end
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         chk("spi_clk",     i, sclk_w[i],       e_clk[i]);
         chk("busy",        i, busy_w[i],       e_busy[i]);
         chk("done",        i, done_w[i],       e_done[i]);
         chk("spi_data_oe", i, soe_w[i],        e_oe[i]);
         chk("spi_data_o",  i, sdo_w[i],        e_do[i]);
         chk("cmd_ready",   i, cmd_ready_w[i],  e_rdy[i]);
         chk("resp_valid",  i, resp_valid_w[i], e_rv[i]);
         chk("resp_data",   i, (i == 0) ? rd0 : rd1, m_rd[i]);
      end
   end

   // Responder: presents response bits MSB first on falling spi_clk, noise elsewhere.
   int         rf[2]   = '{0, 0};
   int         seen[2] = '{0, 0};
   logic [1:0] prev_clk = 2'b11;
   always @(sclk_w) begin
      for (int i = 0; i < 2; i++) begin
         if (prev_clk[i] === 1'b1 && sclk_w[i] === 1'b0) begin
            int f;
            if (seen[i] != acc_id[i]) begin
               seen[i] = acc_id[i];
               rf[i]   = 0;
            end
            f = rf[i] - 64 - T;
            rf[i]++;
            if (m_n[i] > 0 && f >= 0 && f < 8 * m_n[i])
               sdi[i] = m_rb[i][f / 8][7 - (f % 8)];
            else
               sdi[i] = 1'($urandom);
         end
         prev_clk[i] = sclk_w[i];
      end
   end

   task automatic fill_rb(input int i, input int n);
      for (int k = 0; k < n; k++) nxt_rb[i][k] = 8'($urandom);
   endtask

   task automatic run_txn(input int i, input logic [63:0] cmd, input int n, input int lit_done, input logic first_bit);
      int lat, rvc;
      cmd_data = cmd;
      resp_len = 8'(n);
      cmd_valid[i] = 1'b1;
      for (int w = 0; w < 100 && !cmd_ready_w[i]; w++) @(negedge clk);
      @(negedge clk);
      cmd_valid[i] = 1'b0;
      cmd_data = {$urandom, $urandom};
      resp_len = 8'($urandom);
      lat = 0;
      rvc = 0;
      for (int k = 0; k < 20000; k++) begin
         @(negedge clk);
         lat++;
         if (lat == 1) chk("first_bit", i, sdo_w[i], first_bit);
         if (resp_valid_w[i]) rvc++;
         if (done_w[i]) break;
      end
      chk("done_latency", i, lat, lit_done);
      chk("strobe_count", i, rvc, n);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      logic [63:0] c;
      int n, i, dn;
      bit chk_next;
      rst_ = 1'b0;
      cmd_valid = 2'b00;
      cmd_data = '0;
      resp_len = '0;
      for (int a = 0; a < 2; a++) for (int k = 0; k < 256; k++) nxt_rb[a][k] = 8'h00;

      repeat (10) @(negedge clk);
      rst_ = 1'b1;
      repeat (20) @(negedge clk);
      chk("idle_ready", 0, cmd_ready_w[0], 1);
      chk("idle_ready", 1, cmd_ready_w[1], 1);

      run_txn(0, 64'hA5A5_0123_4567_89AB, 0, 257, 1'b1);

      nxt_rb[0][0] = 8'h3C; nxt_rb[0][1] = 8'hFF; nxt_rb[0][2] = 8'h00;
      c = {$urandom, $urandom};
      run_txn(0, c, 3, 385, c[63]);
      chk("last_byte", 0, rd0, 8'h00);

      fill_rb(1, 255);
      c = {$urandom, $urandom};
      run_txn(1, c, 255, 4225, c[63]);

      for (int r = 0; r < 6; r++) begin
         i = $urandom_range(0, 1);
         n = $urandom_range(0, 5);
         fill_rb(i, n);
         c = {$urandom, $urandom};
         run_txn(i, c, n, done_at(i, n), c[63]);
      end

      // continuous cmd_valid with churning inputs
      fill_rb(0, 3);
      dn = 0;
      chk_next = 0;
      cmd_valid[0] = 1'b1;
      for (int k = 0; k < 3000 && dn < 3; k++) begin
         cmd_data = {$urandom, $urandom};
         resp_len = 8'($urandom_range(0, 2));
         @(negedge clk);
         if (chk_next) begin
            chk("b2b_accepted", 0, cmd_ready_w[0], 0);
            chk("b2b_idle_clk", 0, sclk_w[0], 1);
            chk_next = 0;
         end
         if (done_w[0]) begin
            dn++;
            chk_next = 1;
            if (dn == 3) cmd_valid[0] = 1'b0;
         end
      end
      cmd_valid[0] = 1'b0;
      chk("b2b_done_count", 0, dn, 3);
      repeat (5) @(negedge clk);

      // reset during the second response byte
      fill_rb(0, 4);
      cmd_data = {$urandom, $urandom};
      resp_len = 8'd4;
      cmd_valid[0] = 1'b1;
      @(negedge clk);
      cmd_valid[0] = 1'b0;
      for (int k = 0; k < 1000 && m_c[0] < 1 + 4 * (64 + T + 8 + 3); k++) @(negedge clk);
      chk("rst_reached_byte2", 0, (m_c[0] >= 1 + 4 * (64 + T + 8 + 3)) ? 1 : 0, 1);
      #2 rst_ = 1'b0;
      #1;
      chk("rst_async_clk",  0, sclk_w[0], 1);
      chk("rst_async_oe",   0, soe_w[0], 0);
      chk("rst_async_busy", 0, busy_w[0], 0);
      repeat (3) @(negedge clk);
      rst_ = 1'b1;
      repeat (3) @(negedge clk);
      fill_rb(0, 1);
      c = {$urandom, $urandom};
      run_txn(0, c, 1, done_at(0, 1), c[63]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/msp_spi_initiator.md
# msp_spi_initiator

Initiator end of the MSP↔ICE40 half-duplex SPI link: drives the SPI clock and the single bidirectional data line to issue a 64-bit command, then releases the line and clocks in a response of programmable length. Used by the ICE40 simulation bench and by the bring-up harness to exercise the ICE40 app's MSP SPI responder from the MSP side. Sits between a command source (valid/ready) and the pads that connect to the responder's `ice_msp_spi_clk` and `ice_msp_spi_data`.

## Interface
- `CLK_DIV`, 2: SPI half-period in `clk` cycles; legal range 1..255.
- `TURN_BITS`, 8: turnaround SPI clocks between command and response; legal range 1..15.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst_` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command available.
- `cmd_ready` out 1: high only in IDLE; transfer accepted on a cycle with `cmd_valid && cmd_ready`.
- `cmd_data` in 64: command, sent MSB first; captured at acceptance.
- `resp_len` in 8: response byte count N (0..255); captured at acceptance.
- `resp_data` out 8: last received byte, MSB first on the wire.
- `resp_valid` out 1: one-cycle strobe per received byte.
- `busy` out 1: high from the cycle after acceptance until `done`.
- `done` out 1: one-cycle pulse at transaction end.
- `spi_clk` out 1: SPI clock, idles high.
- `spi_data_o` out 1, `spi_data_oe` out 1, `spi_data_i` in 1: tristate data line split for a pad wrapper.

## Operation
- Reset values: `spi_clk`=1, `spi_data_o`=0, `spi_data_oe`=0, `resp_data`=0, `resp_valid`=0, `busy`=0, `done`=0, state IDLE (`cmd_ready`=1). Reset mid-transaction aborts immediately: clock returns high and line is released asynchronously; no `done`.
- Mode 3: initiator changes `spi_data_o` on the `clk` edge that drives `spi_clk` 1→0; samples `spi_data_i` on the `clk` edge that drives `spi_clk` 0→1.
- States: IDLE → CMD (64 bits, `spi_data_oe`=1) → TURN (`TURN_BITS` clocks, `spi_data_oe`=0, line ignored) → RESP (8·N bits, oe=0) → IDLE.
- N=0: CMD → IDLE directly; no turnaround clocks, no `resp_valid`.
- `cmd_valid` while not IDLE is ignored (`cmd_ready`=0); inputs after acceptance do not affect the transaction.
- Bit counter: 9 bits covers 64 command bits and 3-bit in-byte index; byte counter 8 bits counts down from N, terminal at 1 after last byte.
- `spi_data_o` holds its last command bit (LSB) value until `spi_data_oe` falls, then 0.

## Timing
- Acceptance edge = cycle 0. Cycle 1 edge: `busy`=1, `spi_clk`=0, `spi_data_oe`=1, `spi_data_o`=`cmd_data[63]`.
- Each SPI bit: `spi_clk` low `CLK_DIV` cycles, high `CLK_DIV` cycles.
- `spi_data_oe` falls on the same edge as the first TURN falling clock (2·CLK_DIV·64+1 after acceptance).
- Byte k's LSB sampled at its final rising edge; `resp_valid`=1 and `resp_data` updated on the next `clk` edge, held until next byte.
- Last high half completes, then on that edge: state IDLE, `done`=1 for one cycle, `busy`=0, `spi_clk` stays 1. Total: `done` asserts 2·CLK_DIV·(64+T+8N)+1 cycles after acceptance, T=TURN_BITS if N>0 else 0.
- Back-to-back: new command acceptable on the `done` cycle; its first falling clock one cycle later, giving ≥1 cycle of high idle clock between transactions.

## Test plan
- Reset idle: hold `rst_`=0 10 cycles then release -> all outputs at reset values, `cmd_ready`=1, `spi_clk` never toggles with `cmd_valid`=0.
- Command only: `cmd_data`=64'hA5A5_0123_4567_89AB, N=0, CLK_DIV=2 -> 64 clocks, bits sampled at rising edges match MSB-first, `done` exactly 257 cycles after acceptance, `resp_valid` never high.
- Command+response: N=3, responder model drives 8'h3C,8'hFF,8'h00 on falling edges -> three `resp_valid` strobes with those values in order, `spi_data_oe`=0 through TURN/RESP, `done` at 2·2·(64+8+24)+1=385 cycles.
- Boundary: CLK_DIV=1, N=255 -> 255 strobes, byte counter no wrap, `done` at 2·(72+2040)+1=4225 cycles.
- Busy interlock and back-to-back: assert `cmd_valid` continuously with changing data -> mid-transaction changes ignored, second command accepted on `done` cycle.
- Reset mid-response: drop `rst_` during byte 2 of N=4 -> `spi_clk`=1, `spi_data_oe`=0 without waiting for an edge, no `done`; next command runs cleanly.
